// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl
//   Sequencer in front of the 8-bit LFSR and dual bcd7seg display datapath.
//   It turns a raw, bouncing push-button into clean single-cycle step enables:
//   the button is synchronised, debounced, and then drives a small FSM. The FSM
//   issues one step per press, and auto-repeats while the button is held past a
//   threshold.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   btn      in   1  raw button, asynchronous to clk, may bounce
//   step_en  out  1  one-cycle pulse: the LFSR advances on this cycle
//   pressed  out  1  debounced button level
//   auto     out  1  high while the FSM is in the auto-repeat state
//   steps    out  8  number of step_en pulses issued, wraps 255 -> 0
module lfsr_step_ctrl #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned HOLD_CYC     = 64,
    parameter int unsigned REPEAT_CYC   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       step_en,
    output logic       pressed,
    output logic       auto,
    output logic [7:0] steps
);

    // Counter widths: $clog2 of the terminal count, never below one bit.
    // Counters clear at their terminal value, so they never overflow.
    localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYC > 1)     ? $clog2(HOLD_CYC)     : 1;
    localparam int unsigned REP_W  = (REPEAT_CYC > 1)   ? $clog2(REPEAT_CYC)   : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_AUTO
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: btn -> SYNC_STAGES flops -> btn_s
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: pressed flips only after DEBOUNCE_CYC consecutive cycles
    // in which the synchronised level disagrees with it. Any agreeing
    // cycle restarts the count, so short glitches are ignored.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (btn_s != pressed) begin
            if (db_cnt == DB_LAST) begin
                pressed <= ~pressed;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Step FSM. A release always takes priority over a hold or repeat
    // threshold reached in the same cycle, so no pulse is issued then.
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              step_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        step_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_PRESS;
                    step_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            S_PRESS: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_AUTO;
                    step_d  = 1'b1;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_AUTO: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end else if (rep_q == REP_LAST) begin
                    step_d = 1'b1;
                    rep_d  = '0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // step_en, auto and steps are registered so the LFSR sees glitch-free
    // enables; auto is loaded from the next state so it tracks state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            rep_q   <= '0;
            step_en <= 1'b0;
            auto    <= 1'b0;
            steps   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            step_en <= step_d;
            auto    <= (state_d == S_AUTO);
            steps   <= steps + 8'(step_d);
        end
    end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// tb_lfsr_step_ctrl
//   Bench for lfsr_step_ctrl with SYNC_STAGES=2, DEBOUNCE_CYC=4, HOLD_CYC=20,
//   REPEAT_CYC=8. A behavioural model (delay queue, disagreement run length,
//   and "edges held" arithmetic for the step schedule) is compared with the
//   DUT after every clock edge, alongside directed vectors and sequences.
module tb_lfsr_step_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       step_en;
    logic       pressed;
    logic       auto;
    logic [7:0] steps;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_step_ctrl #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (REP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .step_en(step_en),
        .pressed(pressed),
        .auto   (auto),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit   mq[$];        // btn samples still travelling through the synchroniser
    bit   m_pressed;
    int   m_dis;        // consecutive edges where synced level disagreed
    int   m_run;        // consecutive edges the step logic has seen pressed=1
    bit   m_step;
    bit   m_auto;
    int   m_steps;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < int'(SYNC); i++) mq.push_back(1'b0);
        m_pressed = 1'b0;
        m_dis     = 0;
        m_run     = 0;
        m_step    = 1'b0;
        m_auto    = 1'b0;
        m_steps   = 0;
    endfunction

    // One rising edge: every decision uses the values from before the edge.
    function automatic void model_edge(bit b);
        bit bs;
        bit pp;
        bs = mq.pop_front();
        mq.push_back(b);
        pp = m_pressed;
        if (bs != m_pressed) begin
            m_dis++;
            if (m_dis == int'(DEB)) begin
                m_pressed = !m_pressed;
                m_dis     = 0;
            end
        end else begin
            m_dis = 0;
        end
        // Step on the first edge of a press, at HOLD edges held, then every REP.
        if (pp) begin
            m_step = (m_run == 0) ||
                     (m_run >= int'(HOLD) && ((m_run - int'(HOLD)) % int'(REP)) == 0);
            m_run++;
        end else begin
            m_step = 1'b0;
            m_run  = 0;
        end
        m_auto = (m_run > int'(HOLD));
        if (m_step) m_steps = (m_steps + 1) % 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge, update the model, compare all outputs just after.
    task automatic tick();
        @(posedge clk);
        model_edge(btn);
        #1;
        chk("step_en", int'(step_en), int'(m_step));
        chk("pressed", int'(pressed), int'(m_pressed));
        chk("auto",    int'(auto),    int'(m_auto));
        chk("steps",   int'(steps),   m_steps);
    endtask

    // Assert rst between edges and check outputs clear before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_step_en", int'(step_en), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_auto",    int'(auto),    0);
        chk("rst_steps",   int'(steps),   0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    typedef struct {
        int unsigned hi;         // cycles btn held high
        int          exp_steps;  // step_en pulses expected for the press
        bit          exp_auto;   // auto expected to be seen
        int          exp_fall;   // edge where pressed falls (0: never rises)
    } vec_t;

    vec_t vecs[6];

    initial begin
        int npulse;
        int fall_edge;
        bit auto_seen;
        bit prev_p;
        int first;

        vecs[0] = '{hi: 3,  exp_steps: 0, exp_auto: 1'b0, exp_fall: 0};
        vecs[1] = '{hi: 4,  exp_steps: 1, exp_auto: 1'b0, exp_fall: 10};
        vecs[2] = '{hi: 15, exp_steps: 1, exp_auto: 1'b0, exp_fall: 21};
        vecs[3] = '{hi: 20, exp_steps: 1, exp_auto: 1'b0, exp_fall: 26};
        vecs[4] = '{hi: 21, exp_steps: 2, exp_auto: 1'b1, exp_fall: 27};
        vecs[5] = '{hi: 60, exp_steps: 6, exp_auto: 1'b1, exp_fall: 66};

        // Power-on reset.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_step_en", int'(step_en), 0);
        chk("por_pressed", int'(pressed), 0);
        chk("por_auto",    int'(auto),    0);
        chk("por_steps",   int'(steps),   0);
        #4 rst = 1'b0;

        // Bounce: 2 high / 2 low for 40 cycles, then held low.
        for (int c = 0; c < 40; c++) begin
            btn = ((c / 2) % 2) == 0;
            tick();
        end
        btn = 1'b0;
        auto_seen = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("bounce_pressed", int'(pressed), 0);
        chk("bounce_steps",   int'(steps),   0);

        // Table of single presses; 15 low cycles after each.
        for (int v = 0; v < 6; v++) begin
            npulse    = 0;
            fall_edge = 0;
            auto_seen = 1'b0;
            prev_p    = pressed;
            for (int c = 1; c <= int'(vecs[v].hi) + 15; c++) begin
                btn = (c <= int'(vecs[v].hi));
                tick();
                if (step_en) npulse++;
                if (auto) auto_seen = 1'b1;
                if (prev_p && !pressed) fall_edge = c;
                prev_p = pressed;
            end
            chk("vec_pulses", npulse, vecs[v].exp_steps);
            chk("vec_auto",   int'(auto_seen), int'(vecs[v].exp_auto));
            chk("vec_fall",   fall_edge, vecs[v].exp_fall);
        end

        // Reset mid-AUTO, button kept high: next pulse 7 edges after release.
        btn = 1'b1;
        for (int c = 0; c < 32; c++) tick();
        chk("pre_rst_auto", int'(auto), 1);
        async_reset();
        first = 0;
        for (int c = 1; c <= 20 && first == 0; c++) begin
            tick();
            if (step_en) first = c;
        end
        chk("rst_release_latency", first, 7);
        btn = 1'b0;
        for (int c = 0; c < 15; c++) tick();

        // Randomised bursts against the model.
        for (int b = 0; b < 30; b++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 40));
            lo = int'($urandom_range(1, 30));
            btn = 1'b1;
            for (int c = 0; c < hi; c++) tick();
            btn = 1'b0;
            for (int c = 0; c < lo; c++) tick();
        end
        btn = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        // 256 presses from reset: one pulse each, counter wraps to 0.
        async_reset();
        for (int p = 0; p < 256; p++) begin
            npulse = 0;
            btn = 1'b1;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (step_en) npulse++;
            end
            btn = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (step_en) npulse++;
            end
            chk("press_one_pulse", npulse, 1);
        end
        chk("wrap_steps", int'(steps), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
